// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings and control-state type for the sequential ALU.
package alu_seq_pkg;

  localparam logic [3:0] OP_NOT    = 4'b0000;
  localparam logic [3:0] OP_AND    = 4'b0001;
  localparam logic [3:0] OP_OR     = 4'b0010;
  localparam logic [3:0] OP_XOR    = 4'b0011;
  localparam logic [3:0] OP_SHL    = 4'b0100;
  localparam logic [3:0] OP_SHR    = 4'b0101;
  localparam logic [3:0] OP_CUT    = 4'b0110;
  localparam logic [3:0] OP_ADD    = 4'b0111;
  localparam logic [3:0] OP_SUB    = 4'b1000;
  localparam logic [3:0] OP_SAR    = 4'b1001;
  localparam logic [3:0] OP_ROL    = 4'b1010;
  localparam logic [3:0] OP_ROR    = 4'b1011;
  localparam logic [3:0] OP_MUL    = 4'b1100;
  localparam logic [3:0] OP_RSV_LO = 4'b1101;

  typedef enum logic {IDLE, MUL} state_t;

  // Everything from OP_RSV_LO upward is reserved.
  function automatic logic is_rsv(input logic [3:0] op);
    return op >= OP_RSV_LO;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per clock, LSB first.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);
  localparam int SHW = $clog2(WIDTH);

  logic               busy;
  logic [SHW-1:0]     cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;

  // prod already includes the current bit, so the owner can load it on the done edge.
  assign prod = acc + (mplier[0] ? mcand : '0);
  assign done = busy && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= SHW'(WIDTH - 1);
    end else if (busy) begin
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - SHW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
    end else if (busy) begin
      acc    <= prod;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/alu_seq_param.sv
// Registered parametrised ALU with valid/ready handshakes and an iterative MUL.
module alu_seq_param
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             err
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] WIDTH_L = (SHW + 1)'(WIDTH);

  state_t state, state_nxt;
  logic accept, mul_start, mul_done;
  logic [2*WIDTH-1:0] prod;

  logic [SHW-1:0]          n;
  logic [SHW:0]            inv_n;
  logic signed [WIDTH-1:0] a_s, sar_p0;
  logic [WIDTH:0]          add_p0, sub_p0;
  logic [WIDTH-1:0]        res_p0;
  logic                    cout_p0;

  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (opcode == OP_MUL);

  // Stage p0: combinational next result from the live operands.
  assign n      = b[SHW-1:0];
  assign inv_n  = WIDTH_L - {1'b0, n};
  assign a_s    = a;
  assign sar_p0 = a_s >>> n;
  assign add_p0 = {1'b0, a} + {1'b0, b}  + {{WIDTH{1'b0}}, cin};
  assign sub_p0 = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, cin};

  always_comb begin
    res_p0  = '0;
    cout_p0 = 1'b0;
    case (opcode)
      OP_NOT: res_p0 = ~a;
      OP_AND: res_p0 = a & b;
      OP_OR:  res_p0 = a | b;
      OP_XOR: res_p0 = a ^ b;
      OP_SHL: res_p0 = a << n;
      OP_SHR: res_p0 = a >> n;
      OP_CUT: res_p0 = a & ~({WIDTH{1'b1}} << n);
      OP_ADD: {cout_p0, res_p0} = add_p0;
      OP_SUB: {cout_p0, res_p0} = sub_p0;
      OP_SAR: res_p0 = sar_p0;
      // A shift by inv_n == WIDTH yields 0, so n == 0 leaves a unchanged.
      OP_ROL: res_p0 = (a << n) | (a >> inv_n);
      OP_ROR: res_p0 = (a >> n) | (a << inv_n);
      default: res_p0 = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rst_n && (!out_valid || out_ready);
        if (in_valid && in_ready && (opcode == OP_MUL)) state_nxt = MUL;
      end
      MUL:     if (mul_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (a),
    .b     (b),
    .done  (mul_done),
    .prod  (prod)
  );

  // Stage p1: registered result and flags, held until the consumer takes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      zero      <= 1'b0;
      err       <= 1'b0;
    end else if (accept && !mul_start) begin
      out_valid <= 1'b1;
      result    <= res_p0;
      cout      <= cout_p0;
      zero      <= (res_p0 == '0);
      err       <= is_rsv(opcode);
    end else if (mul_done) begin
      out_valid <= 1'b1;
      result    <= prod[WIDTH-1:0];
      cout      <= |prod[2*WIDTH-1:WIDTH];
      zero      <= (prod[WIDTH-1:0] == '0);
      err       <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq_param.sv
// Scoreboard bench for alu_seq_param at WIDTH=32 and WIDTH=16.
module tb_alu_seq_param;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, cin, out_valid, out_ready, cout, zero, err;
  logic [3:0]  opcode;
  logic [31:0] a, b, result;

  logic        in_valid16, in_ready16, cin16, out_valid16, out_ready16, cout16, zero16, err16;
  logic [3:0]  opcode16;
  logic [15:0] a16, b16, result16;

  alu_seq_param #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .zero(zero), .err(err)
  );

  alu_seq_param #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16), .opcode(opcode16),
    .a(a16), .b(b16), .cin(cin16), .out_valid(out_valid16), .out_ready(out_ready16),
    .result(result16), .cout(cout16), .zero(zero16), .err(err16)
  );

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        z;
    logic        e;
  } exp_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic        ci;
    logic [31:0] r;
    logic        c;
  } vec_t;

  exp_t sb[$];
  exp_t sb16[$];
  int n_chk = 0;
  int n_fail = 0;

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                 input logic ci);
    exp_t r;
    logic [32:0] s;
    logic [63:0] p;
    int sh;
    r  = '0;
    sh = int'(y[4:0]);
    case (op)
      OP_NOT: r.res = ~x;
      OP_AND: r.res = x & y;
      OP_OR:  r.res = x | y;
      OP_XOR: r.res = x ^ y;
      OP_SHL: r.res = x << sh;
      OP_SHR: r.res = x >> sh;
      OP_CUT: for (int i = 0; i < sh; i++) r.res[i] = x[i];
      OP_ADD: begin s = {1'b0, x} + {1'b0, y} + {32'b0, ci}; r.res = s[31:0]; r.c = s[32]; end
      OP_SUB: begin s = {1'b0, x} + {1'b0, ~y} + {32'b0, ci}; r.res = s[31:0]; r.c = s[32]; end
      OP_SAR: begin r.res = x; for (int i = 0; i < sh; i++) r.res = {x[31], r.res[31:1]}; end
      OP_ROL: begin r.res = x; for (int i = 0; i < sh; i++) r.res = {r.res[30:0], r.res[31]}; end
      OP_ROR: begin r.res = x; for (int i = 0; i < sh; i++) r.res = {r.res[0], r.res[31:1]}; end
      OP_MUL: begin p = {32'b0, x} * {32'b0, y}; r.res = p[31:0]; r.c = |p[63:32]; end
      default: r.e = 1'b1;
    endcase
    r.z = (r.res == 32'h0);
    return r;
  endfunction

  // Drive one request on the 32-bit DUT and return 1 time unit after its accept edge.
  task automatic send(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y, input logic ci);
    int t;
    opcode = op; a = x; b = y; cin = ci; in_valid = 1'b1;
    #1;
    t = 0;
    while (!in_ready && t < 200) begin @(posedge clk); #1; t++; end
    if (!in_ready) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain;
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    in_valid = 1'b0; opcode = '0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    in_valid16 = 1'b0; opcode16 = '0; a16 = '0; b16 = '0; cin16 = 1'b0; out_ready16 = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    n_chk++;
    if ({in_ready, out_valid, result, cout, zero, err} !== 37'h0) begin
      n_fail++;
      $display("FAIL reset32 got rdy=%b vld=%b res=%h c=%b z=%b e=%b required all 0",
               in_ready, out_valid, result, cout, zero, err);
    end
    n_chk++;
    if ({in_ready16, out_valid16, result16, cout16, zero16, err16} !== 21'h0) begin
      n_fail++;
      $display("FAIL reset16 got rdy=%b vld=%b res=%h c=%b z=%b e=%b required all 0",
               in_ready16, out_valid16, result16, cout16, zero16, err16);
    end
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset got %b required 1", in_ready);
    end
  endtask

  task automatic test_ops;
    vec_t tbl[$];
    exp_t e;
    tbl.push_back(vec_t'{OP_ADD, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, 1'b1});
    tbl.push_back(vec_t'{OP_SUB, 32'h5, 32'h7, 1'b1, 32'hFFFF_FFFE, 1'b0});
    tbl.push_back(vec_t'{OP_SUB, 32'h7, 32'h5, 1'b1, 32'h2, 1'b1});
    tbl.push_back(vec_t'{OP_SAR, 32'h8000_0000, 32'h4, 1'b0, 32'hF800_0000, 1'b0});
    tbl.push_back(vec_t'{OP_ROR, 32'h1, 32'h1, 1'b0, 32'h8000_0000, 1'b0});
    tbl.push_back(vec_t'{OP_ROL, 32'h8000_0001, 32'h4, 1'b0, 32'h18, 1'b0});
    tbl.push_back(vec_t'{OP_CUT, 32'hDEAD_BEEF, 32'h8, 1'b0, 32'hEF, 1'b0});
    tbl.push_back(vec_t'{OP_CUT, 32'hDEAD_BEEF, 32'h0, 1'b0, 32'h0, 1'b0});
    tbl.push_back(vec_t'{OP_SHL, 32'h1, 32'h0, 1'b0, 32'h1, 1'b0});
    tbl.push_back(vec_t'{OP_SHR, 32'hF0, 32'h4, 1'b0, 32'hF, 1'b0});
    tbl.push_back(vec_t'{OP_NOT, 32'h0, 32'h0, 1'b0, 32'hFFFF_FFFF, 1'b0});
    tbl.push_back(vec_t'{OP_XOR, 32'hA5A5, 32'hA5A5, 1'b0, 32'h0, 1'b0});
    tbl.push_back(vec_t'{4'b1110, 32'h1234, 32'h5678, 1'b1, 32'h0, 1'b0});
    tbl.push_back(vec_t'{4'b1101, 32'hFFFF, 32'h1, 1'b1, 32'h0, 1'b0});
    drain();
    foreach (tbl[i]) begin
      e.res = tbl[i].r; e.c = tbl[i].c; e.z = (tbl[i].r == 32'h0); e.e = (tbl[i].op >= 4'd13);
      sb.push_back(e);
      send(tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].ci);
      n_chk++;
      if (out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL ops_latency[%0d] out_valid=%b required 1", i, out_valid);
      end
      e = sb.pop_front();
      n_chk++;
      if ({result, cout, zero, err} !== {e.res, e.c, e.z, e.e}) begin
        n_fail++;
        $display("FAIL ops[%0d] op=%h got res=%h c=%b z=%b e=%b required res=%h c=%b z=%b e=%b",
                 i, tbl[i].op, result, cout, zero, err, e.res, e.c, e.z, e.e);
      end
    end
  endtask

  task automatic test_random;
    logic [3:0] op;
    logic [31:0] x, y;
    logic ci;
    exp_t e;
    drain();
    for (int i = 0; i < 20; i++) begin
      op = 4'($urandom_range(0, 14));
      if (op == OP_MUL) op = OP_ADD;
      x = $urandom; y = $urandom; ci = 1'($urandom_range(0, 1));
      sb.push_back(model(op, x, y, ci));
      send(op, x, y, ci);
      e = sb.pop_front();
      n_chk++;
      if (out_valid !== 1'b1 || {result, cout, zero, err} !== {e.res, e.c, e.z, e.e}) begin
        n_fail++;
        $display("FAIL rand[%0d] op=%h a=%h b=%h got vld=%b res=%h c=%b z=%b e=%b required vld=1 res=%h c=%b z=%b e=%b",
                 i, op, x, y, out_valid, result, cout, zero, err, e.res, e.c, e.z, e.e);
      end
    end
  endtask

  task automatic test_mul;
    logic [31:0] xs[2];
    logic [31:0] ys[2];
    exp_t e;
    int cyc;
    bit busy_ready;
    xs[0] = 32'h0001_0000; ys[0] = 32'h0001_0000;
    xs[1] = 32'd3;         ys[1] = 32'd7;
    drain();
    for (int i = 0; i < 2; i++) begin
      e.res = (i == 0) ? 32'h0 : 32'd21; e.c = (i == 0); e.z = (i == 0); e.e = 1'b0;
      sb.push_back(e);
      send(OP_MUL, xs[i], ys[i], 1'b0);
      cyc = 0; busy_ready = 1'b0;
      while (!out_valid && cyc < 100) begin
        if (in_ready !== 1'b0) busy_ready = 1'b1;
        @(posedge clk); #1; cyc++;
      end
      n_chk++;
      if (cyc != 32 || busy_ready) begin
        n_fail++;
        $display("FAIL mul_latency[%0d] got cycles=%0d ready_seen=%b required cycles=32 ready_seen=0",
                 i, cyc, busy_ready);
      end
      e = sb.pop_front();
      n_chk++;
      if ({result, cout, zero, err} !== {e.res, e.c, e.z, e.e}) begin
        n_fail++;
        $display("FAIL mul[%0d] got res=%h c=%b z=%b e=%b required res=%h c=%b z=%b e=%b",
                 i, result, cout, zero, err, e.res, e.c, e.z, e.e);
      end
    end
  endtask

  task automatic test_backpressure;
    exp_t e;
    drain();
    out_ready = 1'b0;
    sb.push_back(model(OP_AND, 32'hF0F0_1234, 32'hFF00_FF00, 1'b0));
    send(OP_AND, 32'hF0F0_1234, 32'hFF00_FF00, 1'b0);
    opcode = OP_XOR; a = 32'h1111_0000; b = 32'h0101_0101; cin = 1'b0; in_valid = 1'b1;
    sb.push_back(model(OP_XOR, 32'h1111_0000, 32'h0101_0101, 1'b0));
    for (int i = 0; i < 3; i++) begin
      e = sb[0];
      n_chk++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          {result, cout, zero, err} !== {e.res, e.c, e.z, e.e}) begin
        n_fail++;
        $display("FAIL hold[%0d] got vld=%b rdy=%b res=%h c=%b z=%b e=%b required vld=1 rdy=0 res=%h c=%b z=%b e=%b",
                 i, out_valid, in_ready, result, cout, zero, err, e.res, e.c, e.z, e.e);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL release_ready got %b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    void'(sb.pop_front());
    e = sb.pop_front();
    n_chk++;
    if (out_valid !== 1'b1 || {result, cout, zero, err} !== {e.res, e.c, e.z, e.e}) begin
      n_fail++;
      $display("FAIL after_release got vld=%b res=%h required vld=1 res=%h", out_valid, result, e.res);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] ops[5];
    logic [31:0] x, y;
    exp_t e;
    ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_XOR; ops[3] = OP_ROL; ops[4] = OP_SAR;
    drain();
    for (int i = 0; i < 5; i++) begin
      x = $urandom; y = $urandom;
      opcode = ops[i]; a = x; b = y; cin = 1'b1; in_valid = 1'b1;
      sb.push_back(model(ops[i], x, y, 1'b1));
      @(posedge clk); #1;
      e = sb.pop_front();
      n_chk++;
      if (out_valid !== 1'b1 || {result, cout, zero, err} !== {e.res, e.c, e.z, e.e}) begin
        n_fail++;
        $display("FAIL b2b[%0d] got vld=%b res=%h c=%b required vld=1 res=%h c=%b",
                 i, out_valid, result, cout, e.res, e.c);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mul;
    bit seen;
    drain();
    send(OP_OR, 32'h1, 32'h0, 1'b0);
    send(OP_MUL, 32'd5, 32'd9, 1'b0);
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({in_ready, out_valid, result, cout, zero, err} !== 37'h0) begin
      n_fail++;
      $display("FAIL async_reset got rdy=%b vld=%b res=%h c=%b z=%b e=%b required all 0",
               in_ready, out_valid, result, cout, zero, err);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    n_chk++;
    if (seen || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_mul got vld_seen=%b rdy=%b required vld_seen=0 rdy=1", seen, in_ready);
    end
  endtask

  task automatic test_w16;
    logic [3:0]  ops[4];
    logic [15:0] xs[4];
    logic [15:0] ys[4];
    logic [15:0] rs[4];
    logic        cs[4];
    exp_t e;
    int t;
    ops[0] = OP_MUL; xs[0] = 16'hFFFF; ys[0] = 16'hFFFF; rs[0] = 16'h0001; cs[0] = 1'b1;
    ops[1] = OP_ADD; xs[1] = 16'hFFFF; ys[1] = 16'h0;    rs[1] = 16'h0;    cs[1] = 1'b1;
    ops[2] = OP_ROR; xs[2] = 16'h1;    ys[2] = 16'h1;    rs[2] = 16'h8000; cs[2] = 1'b0;
    ops[3] = OP_SAR; xs[3] = 16'h8000; ys[3] = 16'h4;    rs[3] = 16'hF800; cs[3] = 1'b0;
    out_ready16 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e.res = {16'h0, rs[i]}; e.c = cs[i]; e.z = (rs[i] == 16'h0); e.e = 1'b0;
      sb16.push_back(e);
      opcode16 = ops[i]; a16 = xs[i]; b16 = ys[i]; cin16 = 1'b1; in_valid16 = 1'b1;
      #1;
      t = 0;
      while (!in_ready16 && t < 100) begin @(posedge clk); #1; t++; end
      @(posedge clk); #1;
      in_valid16 = 1'b0;
      t = 0;
      while (!out_valid16 && t < 100) begin @(posedge clk); #1; t++; end
      e = sb16.pop_front();
      n_chk++;
      if (t != ((ops[i] == OP_MUL) ? 16 : 0) ||
          {16'h0, result16, cout16, zero16, err16} !== {e.res, e.c, e.z, e.e}) begin
        n_fail++;
        $display("FAIL w16[%0d] got wait=%0d res=%h c=%b z=%b e=%b required wait=%0d res=%h c=%b z=%b e=%b",
                 i, t, result16, cout16, zero16, err16, (ops[i] == OP_MUL) ? 16 : 0,
                 e.res[15:0], e.c, e.z, e.e);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ops();
    test_random();
    test_mul();
    test_backpressure();
    test_back_to_back();
    test_w16();
    test_reset_mul();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
